// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the Beta pipeline controller: ir_src selects, next-PC selects, FSM states.
package pipe_ctrl_pkg;
  localparam int NREG_BITS = 5;
  localparam logic [NREG_BITS-1:0] R_XP = 5'd30;
  localparam logic [NREG_BITS-1:0] R_ZERO = 5'd31;

  localparam logic [1:0] IR_SRC_DATA   = 2'b00;
  localparam logic [1:0] IR_SRC_NOP    = 2'b01;
  localparam logic [1:0] IR_SRC_EXCEPT = 2'b10;

  localparam logic [2:0] PC_SEL_INC   = 3'd0;
  localparam logic [2:0] PC_SEL_BR    = 3'd1;
  localparam logic [2:0] PC_SEL_JMP   = 3'd2;
  localparam logic [2:0] PC_SEL_ILLOP = 3'd3;
  localparam logic [2:0] PC_SEL_XADDR = 3'd4;
  localparam logic [2:0] PC_SEL_RESET = 3'd5;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_XFLUSH = 1'b1
  } fsm_state_e;
endpackage

// File: rtl/pipe_ctrl_if.sv
// Controller-facing bundle: stage decode status in, stall/ir_src/pc_sel controls out.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [NREG_BITS-1:0] rf_ra;
  logic [NREG_BITS-1:0] rf_rb;
  logic                 rf_ra_used;
  logic                 rf_rb_used;
  logic                 rf_illop;
  logic                 rf_br_taken;
  logic                 rf_jmp;
  logic                 rf_kernel;
  logic [NREG_BITS-1:0] exec_rc;
  logic                 exec_ld;
  logic                 mem_wait;
  logic                 irq;

  logic                 stall_if;
  logic                 stall_rf;
  logic                 stall_exec;
  logic [1:0]           ir_src_rf;
  logic [1:0]           ir_src_exec;
  logic [1:0]           ir_src_mem;
  logic [2:0]           pc_sel;
  logic                 irq_ack;

  modport slave (
    input  rf_ra, rf_rb, rf_ra_used, rf_rb_used, rf_illop, rf_br_taken,
           rf_jmp, rf_kernel, exec_rc, exec_ld, mem_wait, irq,
    output stall_if, stall_rf, stall_exec, ir_src_rf, ir_src_exec,
           ir_src_mem, pc_sel, irq_ack
  );

  modport master (
    output rf_ra, rf_rb, rf_ra_used, rf_rb_used, rf_illop, rf_br_taken,
           rf_jmp, rf_kernel, exec_rc, exec_ld, mem_wait, irq,
    input  stall_if, stall_rf, stall_exec, ir_src_rf, ir_src_exec,
           ir_src_mem, pc_sel, irq_ack
  );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use compare between the RF-stage sources and an in-flight load in EXEC.
// R31 reads as zero, so a load targeting it never creates a dependency.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [NREG_BITS-1:0] i_ra,
  input  logic [NREG_BITS-1:0] i_rb,
  input  logic                 i_ra_used,
  input  logic                 i_rb_used,
  input  logic [NREG_BITS-1:0] i_exec_rc,
  input  logic                 i_exec_ld,
  output logic                 o_load_use
);
  logic w_ra_hit;
  logic w_rb_hit;

  assign w_ra_hit   = i_ra_used && (i_ra == i_exec_rc);
  assign w_rb_hit   = i_rb_used && (i_rb == i_exec_rc);
  assign o_load_use = i_exec_ld && (i_exec_rc != R_ZERO) && (w_ra_hit || w_rb_hit);
endmodule

// File: rtl/pipe_ctrl.sv
// Beta 5-stage pipeline controller: stalls, annulment, exception/interrupt entry sequencing.
// Outputs are combinational from the FSM state and current stage status.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);
  logic       w_load_use;
  fsm_state_e r_state;
  fsm_state_e w_state_nxt;
  logic       r_irq_pend;
  logic       w_stall_if;
  logic       w_stall_rf;
  logic       w_stall_exec;
  logic [1:0] w_src_rf;
  logic [1:0] w_src_exec;
  logic [1:0] w_src_mem;
  logic [2:0] w_pc_sel;
  logic       w_irq_ack;

  pipe_ctrl_hazard_detect u_hazard (
    .i_ra       (bus.rf_ra),
    .i_rb       (bus.rf_rb),
    .i_ra_used  (bus.rf_ra_used),
    .i_rb_used  (bus.rf_rb_used),
    .i_exec_rc  (bus.exec_rc),
    .i_exec_ld  (bus.exec_ld),
    .o_load_use (w_load_use)
  );

  always_comb begin
    w_stall_if   = 1'b0;
    w_stall_rf   = 1'b0;
    w_stall_exec = 1'b0;
    w_src_rf     = IR_SRC_DATA;
    w_src_exec   = IR_SRC_DATA;
    w_src_mem    = IR_SRC_DATA;
    w_pc_sel     = PC_SEL_INC;
    w_irq_ack    = 1'b0;
    w_state_nxt  = r_state;

    if (rst) begin
      w_src_rf   = IR_SRC_NOP;
      w_src_exec = IR_SRC_NOP;
      w_src_mem  = IR_SRC_NOP;
      w_pc_sel   = PC_SEL_RESET;
    end else if (bus.mem_wait) begin
      w_stall_if   = 1'b1;
      w_stall_rf   = 1'b1;
      w_stall_exec = 1'b1;
    end else if (w_load_use) begin
      // Bubble into EXEC; redirects wait until the dependent instruction can issue.
      w_stall_if = 1'b1;
      w_stall_rf = 1'b1;
      w_src_exec = IR_SRC_NOP;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.rf_illop) begin
            w_src_exec  = IR_SRC_EXCEPT;
            w_src_rf    = IR_SRC_NOP;
            w_pc_sel    = PC_SEL_ILLOP;
            w_state_nxt = ST_XFLUSH;
          end else if (r_irq_pend && !bus.rf_kernel) begin
            w_src_exec  = IR_SRC_EXCEPT;
            w_src_rf    = IR_SRC_NOP;
            w_pc_sel    = PC_SEL_XADDR;
            w_irq_ack   = 1'b1;
            w_state_nxt = ST_XFLUSH;
          end else if (bus.rf_br_taken) begin
            w_src_rf = IR_SRC_NOP;
            w_pc_sel = bus.rf_jmp ? PC_SEL_JMP : PC_SEL_BR;
          end
        end
        ST_XFLUSH: begin
          // RF holds the fetch that followed the trapping instruction.
          w_src_rf    = IR_SRC_NOP;
          w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_irq_pend <= 1'b0;
    end else if (!bus.mem_wait) begin
      r_state <= w_state_nxt;
      if (w_irq_ack)
        r_irq_pend <= 1'b0;
      else if (bus.irq)
        r_irq_pend <= 1'b1;
    end
  end

  assign bus.stall_if    = w_stall_if;
  assign bus.stall_rf    = w_stall_rf;
  assign bus.stall_exec  = w_stall_exec;
  assign bus.ir_src_rf   = w_src_rf;
  assign bus.ir_src_exec = w_src_exec;
  assign bus.ir_src_mem  = w_src_mem;
  assign bus.pc_sel      = w_pc_sel;
  assign bus.irq_ack     = w_irq_ack;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: reset/table vectors, hand-written exception sequences, then random traffic vs a rule model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    logic       rst;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       ra_used;
    logic       rb_used;
    logic       illop;
    logic       br_taken;
    logic       jmp;
    logic       kernel;
    logic [4:0] exec_rc;
    logic       exec_ld;
    logic       mem_wait;
    logic       irq;
  } in_t;

  typedef struct packed {
    logic [2:0] stalls;
    logic [1:0] src_rf;
    logic [1:0] src_exec;
    logic [1:0] src_mem;
    logic [2:0] pc_sel;
    logic       irq_ack;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  bit   m_flush;
  bit   m_pend;
  vec_t tbl[$];

  pipe_ctrl_if u_if();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk(logic [2:0] st, logic [1:0] rf, logic [1:0] ex, logic [1:0] mem,
                              logic [2:0] pc, logic ack);
    out_t o;
    o.stalls = st; o.src_rf = rf; o.src_exec = ex; o.src_mem = mem; o.pc_sel = pc; o.irq_ack = ack;
    return o;
  endfunction

  function automatic in_t idle();
    in_t v;
    v = '0;
    return v;
  endfunction

  function automatic in_t hz(logic ld, logic [4:0] rc, logic [4:0] ra, logic rau, logic [4:0] rb, logic rbu);
    in_t v;
    v = idle();
    v.exec_ld = ld; v.exec_rc = rc; v.ra = ra; v.ra_used = rau; v.rb = rb; v.rb_used = rbu;
    return v;
  endfunction

  function automatic in_t br(logic jmp, logic kernel);
    in_t v;
    v = idle();
    v.br_taken = 1'b1; v.jmp = jmp; v.kernel = kernel;
    return v;
  endfunction

  // Rule model: a load result is unavailable to any source the RF instruction reads.
  function automatic bit load_use(in_t v);
    logic [4:0] srcs[2];
    bit         used[2];
    if (!v.exec_ld || v.exec_rc == 5'd31) return 1'b0;
    srcs[0] = v.ra; used[0] = v.ra_used;
    srcs[1] = v.rb; used[1] = v.rb_used;
    foreach (srcs[k]) if (used[k] && srcs[k] == v.exec_rc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic out_t model_out(in_t v);
    out_t normal;
    normal = mk(3'b000, IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA, PC_SEL_INC, 1'b0);
    if (v.rst) return mk(3'b000, IR_SRC_NOP, IR_SRC_NOP, IR_SRC_NOP, PC_SEL_RESET, 1'b0);
    if (v.mem_wait) return mk(3'b111, IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA, PC_SEL_INC, 1'b0);
    if (load_use(v)) return mk(3'b110, IR_SRC_DATA, IR_SRC_NOP, IR_SRC_DATA, PC_SEL_INC, 1'b0);
    if (m_flush) return mk(3'b000, IR_SRC_NOP, IR_SRC_DATA, IR_SRC_DATA, PC_SEL_INC, 1'b0);
    if (v.illop) return mk(3'b000, IR_SRC_NOP, IR_SRC_EXCEPT, IR_SRC_DATA, PC_SEL_ILLOP, 1'b0);
    if (m_pend && !v.kernel) return mk(3'b000, IR_SRC_NOP, IR_SRC_EXCEPT, IR_SRC_DATA, PC_SEL_XADDR, 1'b1);
    if (v.br_taken)
      return mk(3'b000, IR_SRC_NOP, IR_SRC_DATA, IR_SRC_DATA, v.jmp ? PC_SEL_JMP : PC_SEL_BR, 1'b0);
    return normal;
  endfunction

  function automatic void model_update(in_t v, out_t o);
    if (v.rst) begin
      m_flush = 1'b0;
      m_pend  = 1'b0;
    end else if (!v.mem_wait) begin
      if (!load_use(v)) m_flush = (o.src_exec == IR_SRC_EXCEPT);
      m_pend = o.irq_ack ? 1'b0 : (m_pend | v.irq);
    end
  endfunction

  task automatic apply(input in_t v);
    rst              = v.rst;
    u_if.rf_ra       = v.ra;
    u_if.rf_rb       = v.rb;
    u_if.rf_ra_used  = v.ra_used;
    u_if.rf_rb_used  = v.rb_used;
    u_if.rf_illop    = v.illop;
    u_if.rf_br_taken = v.br_taken;
    u_if.rf_jmp      = v.jmp;
    u_if.rf_kernel   = v.kernel;
    u_if.exec_rc     = v.exec_rc;
    u_if.exec_ld     = v.exec_ld;
    u_if.mem_wait    = v.mem_wait;
    u_if.irq         = v.irq;
  endtask

  // One clock: drive after the falling edge, sample mid-low-phase, then advance the model.
  task automatic step(input in_t v, input string nm, input bit use_model, input out_t exp);
    out_t act;
    out_t mexp;
    @(negedge clk);
    apply(v);
    #2;
    act = mk({u_if.stall_if, u_if.stall_rf, u_if.stall_exec}, u_if.ir_src_rf, u_if.ir_src_exec,
             u_if.ir_src_mem, u_if.pc_sel, u_if.irq_ack);
    mexp = model_out(v);
    if (use_model) exp = mexp;
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got stalls=%b rf=%0d ex=%0d mem=%0d pc=%0d ack=%b, want stalls=%b rf=%0d ex=%0d mem=%0d pc=%0d ack=%b",
                  nm, act.stalls, act.src_rf, act.src_exec, act.src_mem, act.pc_sel, act.irq_ack,
                  exp.stalls, exp.src_rf, exp.src_exec, exp.src_mem, exp.pc_sel, exp.irq_ack);
    model_update(v, mexp);
  endtask

  task automatic add_vec(input string n, input in_t i, input out_t e);
    vec_t t;
    t.name = n; t.in = i; t.exp = e;
    tbl.push_back(t);
  endtask

  initial begin
    in_t  v;
    out_t o_norm;
    out_t o_rst;
    out_t o_stall;
    out_t o_flush;
    out_t o_xirq;
    out_t o_xill;
    out_t o_freeze;

    n_pass = 0; n_total = 0; m_flush = 1'b0; m_pend = 1'b0;
    o_norm   = mk(3'b000, IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA, PC_SEL_INC, 1'b0);
    o_rst    = mk(3'b000, IR_SRC_NOP, IR_SRC_NOP, IR_SRC_NOP, PC_SEL_RESET, 1'b0);
    o_stall  = mk(3'b110, IR_SRC_DATA, IR_SRC_NOP, IR_SRC_DATA, PC_SEL_INC, 1'b0);
    o_flush  = mk(3'b000, IR_SRC_NOP, IR_SRC_DATA, IR_SRC_DATA, PC_SEL_INC, 1'b0);
    o_xirq   = mk(3'b000, IR_SRC_NOP, IR_SRC_EXCEPT, IR_SRC_DATA, PC_SEL_XADDR, 1'b1);
    o_xill   = mk(3'b000, IR_SRC_NOP, IR_SRC_EXCEPT, IR_SRC_DATA, PC_SEL_ILLOP, 1'b0);
    o_freeze = mk(3'b111, IR_SRC_DATA, IR_SRC_DATA, IR_SRC_DATA, PC_SEL_INC, 1'b0);
    apply(idle());

    v = idle(); v.rst = 1'b1;
    step(v, "reset_c1", 1'b0, o_rst);
    step(v, "reset_c2", 1'b0, o_rst);
    step(idle(), "reset_release", 1'b0, o_norm);

    add_vec("lu_ra",        hz(1, 5'd3, 5'd3, 1, 5'd0, 0),  o_stall);
    add_vec("lu_r31",       hz(1, 5'd31, 5'd31, 1, 5'd31, 1), o_norm);
    add_vec("lu_rb",        hz(1, 5'd7, 5'd1, 1, 5'd7, 1),  o_stall);
    add_vec("lu_rb_unused", hz(1, 5'd7, 5'd1, 1, 5'd7, 0),  o_norm);
    add_vec("lu_not_load",  hz(0, 5'd3, 5'd3, 1, 5'd3, 1),  o_norm);
    add_vec("lu_xp",        hz(1, R_XP, 5'd2, 1, R_XP, 1),  o_stall);
    add_vec("br_taken",     br(1'b0, 1'b0), mk(3'b000, IR_SRC_NOP, IR_SRC_DATA, IR_SRC_DATA, PC_SEL_BR, 1'b0));
    add_vec("jmp_taken",    br(1'b1, 1'b0), mk(3'b000, IR_SRC_NOP, IR_SRC_DATA, IR_SRC_DATA, PC_SEL_JMP, 1'b0));
    add_vec("br_kernel",    br(1'b0, 1'b1), mk(3'b000, IR_SRC_NOP, IR_SRC_DATA, IR_SRC_DATA, PC_SEL_BR, 1'b0));
    v = br(1'b0, 1'b0); v.exec_ld = 1; v.exec_rc = 5'd4; v.ra = 5'd4; v.ra_used = 1;
    add_vec("br_under_lu",  v, o_stall);
    v = idle(); v.mem_wait = 1;
    add_vec("mem_wait",     v, o_freeze);
    v = br(1'b1, 1'b0); v.mem_wait = 1;
    add_vec("mem_wait_br",  v, o_freeze);
    foreach (tbl[i]) step(tbl[i].in, tbl[i].name, 1'b0, tbl[i].exp);

    // illop beats a pending irq; the irq is taken after the flush cycle
    v = idle(); v.irq = 1;
    step(v, "ill_irq_pulse", 1'b0, o_norm);
    v = idle(); v.illop = 1;
    step(v, "ill_entry", 1'b0, o_xill);
    v = br(1'b0, 1'b0); v.illop = 1; v.irq = 1;
    step(v, "ill_xflush", 1'b0, o_flush);
    step(idle(), "ill_then_irq", 1'b0, o_xirq);
    step(idle(), "ill_irq_xflush", 1'b0, o_flush);
    step(idle(), "ill_back_run", 1'b0, o_norm);

    // kernel mode masks the interrupt until pc[31] drops
    v = idle(); v.irq = 1; v.kernel = 1;
    for (int i = 0; i < 5; i++) step(v, $sformatf("kmask_c%0d", i), 1'b0, o_norm);
    step(idle(), "kmask_release", 1'b0, o_xirq);
    step(idle(), "kmask_xflush", 1'b0, o_flush);
    step(idle(), "kmask_no_reack", 1'b0, o_norm);

    // memory wait freezes everything, including irq sampling
    v = hz(1, 5'd3, 5'd3, 1, 5'd0, 0); v.irq = 1; v.mem_wait = 1;
    for (int i = 0; i < 3; i++) step(v, $sformatf("mw_freeze_c%0d", i), 1'b0, o_freeze);
    v.mem_wait = 0;
    step(v, "mw_bubble_first", 1'b0, o_stall);
    step(idle(), "mw_irq_entry", 1'b0, o_xirq);
    step(idle(), "mw_xflush", 1'b0, o_flush);
    v = idle(); v.irq = 1; v.mem_wait = 1;
    step(v, "mw_irq_masked", 1'b0, o_freeze);
    step(idle(), "mw_irq_not_pend", 1'b0, o_norm);

    // reset during XFLUSH drops both the flush and a pending irq
    v = idle(); v.irq = 1;
    step(v, "rx_pulse", 1'b0, o_norm);
    v = idle(); v.illop = 1;
    step(v, "rx_entry", 1'b0, o_xill);
    v = idle(); v.rst = 1;
    step(v, "rx_reset", 1'b0, o_rst);
    step(idle(), "rx_no_flush", 1'b0, o_norm);
    step(idle(), "rx_irq_lost", 1'b0, o_norm);

    for (int i = 0; i < 1500; i++) begin
      v = idle();
      v.rst      = ($urandom_range(0, 60) == 0);
      v.ra       = 5'($urandom_range(0, 3));
      v.rb       = 5'($urandom_range(0, 3));
      v.ra_used  = 1'($urandom_range(0, 1));
      v.rb_used  = 1'($urandom_range(0, 1));
      v.illop    = ($urandom_range(0, 9) == 0);
      v.br_taken = ($urandom_range(0, 3) == 0);
      v.jmp      = 1'($urandom_range(0, 1));
      v.kernel   = ($urandom_range(0, 2) == 0);
      v.exec_rc  = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(1, 3));
      v.exec_ld  = ($urandom_range(0, 3) == 0);
      v.mem_wait = ($urandom_range(0, 5) == 0);
      v.irq      = ($urandom_range(0, 7) == 0);
      step(v, $sformatf("rand_%0d", i), 1'b1, o_norm);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
